// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, addresses the instruction ROM and assembles
// one- or two-byte instructions for decode over a valid/ready handshake.
module instruction_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic [7:0] ir_op,
  output logic [7:0] ir_imm,
  output logic [7:0] ir_pc,
  input  logic       redirect,
  input  logic [7:0] redirect_addr,
  output logic       halted
);
  localparam logic [1:0] FETCH_OP  = 2'd0;
  localparam logic [1:0] FETCH_IMM = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] HALT      = 2'd3;
  logic [1:0] state;
  logic [7:0] pc;
  logic       two_byte;
  logic       is_hlt;
  assign imem_addr = pc;
  always_comb begin
    two_byte = imem_data[7:4] == 4'b1001 || imem_data[7:4] == 4'b1100 || imem_data[7:4] == 4'b1101;
    is_hlt   = ir_op[7:4] == 4'b1110;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH_OP;
      pc       <= RESET_PC;
      ir_valid <= 1'b0;
      ir_op    <= 8'h00;
      ir_imm   <= 8'h00;
      ir_pc    <= 8'h00;
      halted   <= 1'b0;
    end else if (redirect && state != HALT) begin
      // a handshake in the same cycle is void: the held instruction is dropped
      pc       <= redirect_addr;
      state    <= FETCH_OP;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          ir_op    <= imem_data;
          ir_pc    <= pc;
          pc       <= pc + 8'd1;
          state    <= two_byte ? FETCH_IMM : HOLD;
          ir_valid <= !two_byte;
          if (!two_byte) ir_imm <= 8'h00;
        end
        FETCH_IMM: begin
          ir_imm   <= imem_data;
          pc       <= pc + 8'd1;
          state    <= HOLD;
          ir_valid <= 1'b1;
        end
        HOLD: if (ir_ready) begin
          ir_valid <= 1'b0;
          state    <= is_hlt ? HALT : FETCH_OP;
          halted   <= is_hlt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven and directed checks with a handshake scoreboard.
module tb_instruction_fetch;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       ir_valid;
  logic       ir_ready = 1'b0;
  logic [7:0] ir_op, ir_imm, ir_pc;
  logic       redirect = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic       halted;
  logic [7:0] mem [256];
  int checks = 0;
  int failures = 0;

  typedef struct { logic [7:0] addr, b0, b1; } vec_t;
  typedef struct { logic [7:0] op, imm, pc; } exp_t;
  exp_t q[$];

  instruction_fetch #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_op(ir_op), .ir_imm(ir_imm),
    .ir_pc(ir_pc), .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted)
  );

  assign imem_data = mem[imem_addr];
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [39:0] a, input logic [39:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // scoreboard: every real handshake must match the oldest expected instruction
  always @(negedge clk) begin
    if (!rst && ir_valid && ir_ready && !redirect) begin
      if (q.size() == 0) chk("unexpected_handshake", {16'h0, ir_op, ir_imm, ir_pc}, 40'h0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("handshake", {16'h0, ir_op, ir_imm, ir_pc}, {16'h0, e.op, e.imm, e.pc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [7:0] a);
    redirect = 1'b1;
    redirect_addr = a;
    step();
    redirect = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!ir_valid && lat < 8);
    if (!ir_valid) chk("valid_timeout", 40'(ir_valid), 40'h1);
  endtask

  task automatic accept();
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
  endtask

  function automatic bit is_two(input logic [7:0] b);
    return b[7:4] == 4'h9 || b[7:4] == 4'hC || b[7:4] == 4'hD;
  endfunction

  initial begin
    vec_t vt[6];
    int lat;
    vt[0] = '{8'h04, 8'h11, 8'h77};
    vt[1] = '{8'h10, 8'hC0, 8'h33};
    vt[2] = '{8'h20, 8'hD4, 8'h77};
    vt[3] = '{8'h30, 8'h95, 8'h5A};
    vt[4] = '{8'h50, 8'h2B, 8'h99};
    vt[5] = '{8'h60, 8'hA0, 8'h12};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h90;
    mem[1] = 8'h05;
    step();
    step();
    chk("reset_state", {7'h0, ir_valid, ir_op, ir_imm, ir_pc, imem_addr}, 40'h0);
    chk("reset_halted", 40'(halted), 40'h0);
    rst = 1'b0;
    q.push_back('{8'h90, 8'h05, 8'h00});
    step();
    chk("ldi_fetch_imm", {31'h0, ir_valid, imem_addr}, {31'h0, 1'b0, 8'h01});
    step();
    chk("ldi_present", {7'h0, ir_valid, ir_op, ir_imm, ir_pc, imem_addr}, {7'h0, 1'b1, 32'h90050002});
    for (int i = 0; i < 5; i++) begin
      step();
      chk("backpressure_stable", {7'h0, ir_valid, ir_op, ir_imm, ir_pc, imem_addr}, {7'h0, 1'b1, 32'h90050002});
    end
    accept();
    chk("after_release", {31'h0, ir_valid, imem_addr}, {31'h0, 1'b0, 8'h02});
    for (int i = 0; i < 6; i++) begin
      logic [7:0] len;
      len = is_two(vt[i].b0) ? 8'd2 : 8'd1;
      mem[vt[i].addr] = vt[i].b0;
      mem[vt[i].addr + 8'd1] = vt[i].b1;
      q.push_back('{vt[i].b0, is_two(vt[i].b0) ? vt[i].b1 : 8'h00, vt[i].addr});
      redir(vt[i].addr);
      wait_valid(lat);
      chk("latency", 40'(lat), 40'(len));
      chk("pc_after_fetch", 40'(imem_addr), 40'(vt[i].addr + len));
      accept();
      chk("valid_one_cycle", {31'h0, ir_valid, imem_addr}, {31'h0, 1'b0, vt[i].addr + len});
    end
    mem[8'h40] = 8'h3C;
    redir(8'h30);
    step();
    redirect = 1'b1;
    redirect_addr = 8'h40;
    step();
    redirect = 1'b0;
    chk("redirect_imm", {31'h0, ir_valid, imem_addr}, {31'h0, 1'b0, 8'h40});
    q.push_back('{8'h3C, 8'h00, 8'h40});
    wait_valid(lat);
    chk("redirect_imm_lat", 40'(lat), 40'd1);
    accept();
    redir(8'h10);
    wait_valid(lat);
    ir_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 8'h50;
    step();
    ir_ready = 1'b0;
    redirect = 1'b0;
    chk("redirect_hold", {31'h0, ir_valid, imem_addr}, {31'h0, 1'b0, 8'h50});
    q.push_back('{8'h2B, 8'h00, 8'h50});
    wait_valid(lat);
    accept();
    mem[8'h0B] = 8'hE0;
    q.push_back('{8'hE0, 8'h00, 8'h0B});
    redir(8'h0B);
    wait_valid(lat);
    accept();
    chk("halt_entry", {30'h0, halted, ir_valid, imem_addr}, {30'h0, 2'b10, 8'h0C});
    redirect = 1'b1;
    redirect_addr = 8'h40;
    ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_sticky", {30'h0, halted, ir_valid, imem_addr}, {30'h0, 2'b10, 8'h0C});
    end
    redirect = 1'b0;
    ir_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("halt_reset", {7'h0, halted, ir_valid, ir_op, ir_imm, ir_pc, imem_addr}, 40'h0);
    rst = 1'b0;
    step();
    chk("restart_fetch", {31'h0, ir_valid, imem_addr}, {31'h0, 1'b0, 8'h01});
    rst = 1'b1;
    step();
    chk("reset_mid", {7'h0, halted, ir_valid, ir_op, ir_imm, ir_pc, imem_addr}, 40'h0);
    rst = 1'b0;
    mem[8'hFF] = 8'h9C;
    mem[8'h00] = 8'h2A;
    q.push_back('{8'h9C, 8'h2A, 8'hFF});
    redir(8'hFF);
    wait_valid(lat);
    chk("wrap_lat", 40'(lat), 40'd2);
    chk("wrap_addr", 40'(imem_addr), 40'h01);
    accept();
    chk("scoreboard_drained", 40'(q.size()), 40'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
